mux_n_1_scan: RTL and testbench



---
 rtl/mux_n_1_scan_pkg.sv | 17 +
 rtl/mux_n_1_scan_rr_scan_ctrl.sv | 61 ++++++
 rtl/mux_n_1_scan.sv | 87 ++++++++
 tb/tb_mux_n_1_scan.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mux_n_1_scan_pkg.sv
// Shared definitions for the registered N:1 scan multiplexer.
// Mode encodings and a constant-friendly ceiling-log2 helper.
package mux_n_1_scan_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_n_1_scan_rr_scan_ctrl.sv
// Round-robin scan controller: dwell counter, scan channel index and wrap pulse.
// Manual mode parks the counter at zero and follows the last in-range select.
module rr_scan_ctrl
  import mux_n_1_scan_pkg::*;
#(
  parameter int N     = 3,
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             sel_ok,
  output logic [SEL_W-1:0] scan_idx,
  output logic             wrap
);

  localparam int CNT_W = clog2(DWELL) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N - 1);

  logic [CNT_W-1:0] dwell_cnt, dwell_nxt;
  logic [SEL_W-1:0] sel_q, sel_nxt;
  logic             wrap_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_cnt <= '0;
      sel_q     <= '0;
      wrap      <= 1'b0;
    end else begin
      dwell_cnt <= dwell_nxt;
      sel_q     <= sel_nxt;
      wrap      <= wrap_nxt;
    end
  end

  always_comb begin
    dwell_nxt = dwell_cnt;
    sel_nxt   = sel_q;
    wrap_nxt  = 1'b0;
    if (en) begin
      if (mode == MODE_MANUAL) begin
        dwell_nxt = '0;
        if (sel_ok) sel_nxt = sel;
      end else if (dwell_cnt == CNT_LAST) begin
        // Last dwell sample of this channel: step on, wrapping after N-1.
        dwell_nxt = '0;
        wrap_nxt  = (sel_q == IDX_LAST);
        sel_nxt   = (sel_q == IDX_LAST) ? '0 : sel_q + SEL_W'(1);
      end else begin
        dwell_nxt = dwell_cnt + CNT_W'(1);
      end
    end
  end

  assign scan_idx = sel_q;

endmodule

// File: rtl/mux_n_1_scan.sv
// Registered N:1 multiplexer with manual select and round-robin scan mode.
// Out-of-range manual selects output zero and raise sel_err.
module mux_n_1_scan
  import mux_n_1_scan_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 3,
  parameter int SEL_W = $clog2(N),
  parameter int DWELL = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] d,
  output logic [WIDTH-1:0]   y,
  output logic               y_valid,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               sel_err,
  output logic               wrap
);

  localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(N);

  logic [WIDTH-1:0] chan [N];
  logic [WIDTH-1:0] data_sel;
  logic [SEL_W-1:0] scan_idx;
  logic [SEL_W-1:0] idx;
  logic             sel_ok;

  for (genvar i = 0; i < N; i++) begin : g_chan
    assign chan[i] = d[i*WIDTH +: WIDTH];
  end

  assign sel_ok = ({1'b0, sel} < N_EXT);
  assign idx    = (mode == MODE_SCAN) ? scan_idx : sel;

  // Unused codes match no channel and fall through to zero.
  always_comb begin
    data_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == SEL_W'(i)) data_sel = chan[i];
    end
  end

  rr_scan_ctrl #(
    .N     (N),
    .SEL_W (SEL_W),
    .DWELL (DWELL)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .sel      (sel),
    .sel_ok   (sel_ok),
    .scan_idx (scan_idx),
    .wrap     (wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y       <= '0;
      y_valid <= 1'b0;
      cur_sel <= '0;
      sel_err <= 1'b0;
    end else if (en) begin
      y_valid <= 1'b1;
      if (mode == MODE_SCAN) begin
        y       <= data_sel;
        cur_sel <= scan_idx;
        sel_err <= 1'b0;
      end else if (sel_ok) begin
        y       <= data_sel;
        cur_sel <= sel;
        sel_err <= 1'b0;
      end else begin
        y       <= '0;
        sel_err <= 1'b1;
      end
    end else begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n_1_scan.sv
// Self-checking bench for mux_n_1_scan: directed literal checks plus a
// cycle-by-cycle comparison against a behavioural model.
module tb_mux_n_1_scan;

  localparam int WIDTH = 8;
  localparam int N     = 3;
  localparam int SEL_W = 2;
  localparam int DWELL = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [N*WIDTH-1:0] d;
  logic [WIDTH-1:0]   y;
  logic               y_valid;
  logic [SEL_W-1:0]   cur_sel;
  logic               sel_err;
  logic               wrap;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  run_cmp  = 1'b0;

  int m_y, m_v, m_cur, m_err, m_wrap, m_pos, m_cnt;

  always #5 clk = ~clk;

  mux_n_1_scan #(
    .WIDTH (WIDTH),
    .N     (N),
    .DWELL (DWELL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .sel     (sel),
    .d       (d),
    .y       (y),
    .y_valid (y_valid),
    .cur_sel (cur_sel),
    .sel_err (sel_err),
    .wrap    (wrap)
  );

  function automatic int chan_val(input int i);
    return int'(d[i*WIDTH +: WIDTH]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: scan position advances after DWELL samples per channel.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_y = 0; m_v = 0; m_cur = 0; m_err = 0; m_wrap = 0; m_pos = 0; m_cnt = 0;
    end else if (!en) begin
      m_v = 0; m_wrap = 0;
    end else if (mode == 1'b0) begin
      m_v = 1; m_wrap = 0; m_cnt = 0;
      if (int'(sel) < N) begin
        m_y = chan_val(int'(sel)); m_cur = int'(sel); m_pos = int'(sel); m_err = 0;
      end else begin
        m_y = 0; m_err = 1;
      end
    end else begin
      m_v = 1; m_err = 0; m_wrap = 0;
      m_y = chan_val(m_pos); m_cur = m_pos;
      m_cnt = m_cnt + 1;
      if (m_cnt == DWELL) begin
        m_cnt  = 0;
        m_wrap = (m_pos == N - 1) ? 1 : 0;
        m_pos  = (m_pos + 1) % N;
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp && !rst) begin
      chk("model_y",       32'(y),       32'(m_y));
      chk("model_y_valid", 32'(y_valid), 32'(m_v));
      chk("model_cur_sel", 32'(cur_sel), 32'(m_cur));
      chk("model_sel_err", 32'(sel_err), 32'(m_err));
      chk("model_wrap",    32'(wrap),    32'(m_wrap));
    end
  end

  task automatic cyc(input bit e, input bit m, input logic [SEL_W-1:0] s);
    en = e; mode = m; sel = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wraps;
    int exp_y;
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel = '0; d = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_y_valid", 32'(y_valid), 32'h0);
    chk("rst_cur_sel", 32'(cur_sel), 32'h0);
    chk("rst_sel_err", 32'(sel_err), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    rst = 1'b0;
    run_cmp = 1'b1;

    // Asynchronous reset mid-operation.
    d = {8'h33, 8'hAA, 8'h11};
    cyc(1'b1, 1'b0, 2'd1);
    chk("pre_rst_y", 32'(y), 32'hAA);
    chk("pre_rst_cur_sel", 32'(cur_sel), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_y", 32'(y), 32'h0);
    chk("async_rst_y_valid", 32'(y_valid), 32'h0);
    chk("async_rst_cur_sel", 32'(cur_sel), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Manual selection of each channel.
    d = {8'h33, 8'h22, 8'h11};
    for (int i = 0; i < N; i++) begin
      cyc(1'b1, 1'b0, SEL_W'(i));
      chk("man_y", 32'(y), 32'h11 * (i + 1));
      chk("man_cur_sel", 32'(cur_sel), 32'(i));
      chk("man_sel_err", 32'(sel_err), 32'h0);
      chk("man_y_valid", 32'(y_valid), 32'h1);
    end

    // Out-of-range select, then recovery.
    cyc(1'b1, 1'b0, 2'd3);
    chk("oor_y", 32'(y), 32'h0);
    chk("oor_sel_err", 32'(sel_err), 32'h1);
    chk("oor_cur_sel", 32'(cur_sel), 32'h2);
    cyc(1'b1, 1'b0, 2'd1);
    chk("recover_y", 32'(y), 32'h22);
    chk("recover_sel_err", 32'(sel_err), 32'h0);

    // Full scan cycle from channel 0.
    cyc(1'b1, 1'b0, 2'd0);
    wraps = 0;
    for (int i = 0; i < 3 * DWELL; i++) begin
      cyc(1'b1, 1'b1, 2'd0);
      exp_y = (i < 4) ? 'h11 : (i < 8) ? 'h22 : 'h33;
      chk("scan_y", 32'(y), 32'(exp_y));
      chk("scan_cur_sel", 32'(cur_sel), 32'(i / DWELL));
      chk("scan_wrap", 32'(wrap), (i == 3 * DWELL - 1) ? 32'h1 : 32'h0);
      wraps += int'(wrap);
    end
    chk("scan_wrap_count", 32'(wraps), 32'h1);

    // Scan with en dropped during channel 1 after two dwell samples.
    for (int i = 0; i < DWELL; i++) cyc(1'b1, 1'b1, 2'd0);
    chk("pause_pre_y0", 32'(y), 32'h11);
    cyc(1'b1, 1'b1, 2'd0);
    cyc(1'b1, 1'b1, 2'd0);
    chk("pause_pre_y1", 32'(y), 32'h22);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 2'd0);
      chk("pause_y", 32'(y), 32'h22);
      chk("pause_cur_sel", 32'(cur_sel), 32'h1);
      chk("pause_y_valid", 32'(y_valid), 32'h0);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b1, 2'd0);
      chk("resume_y", 32'(y), 32'h22);
      chk("resume_y_valid", 32'(y_valid), 32'h1);
    end
    cyc(1'b1, 1'b1, 2'd0);
    chk("resume_next_y", 32'(y), 32'h33);
    chk("resume_next_cur_sel", 32'(cur_sel), 32'h2);

    // Random traffic checked by the model each cycle.
    for (int i = 0; i < 1000; i++) begin
      d = N*WIDTH'($urandom);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      en  = ($urandom_range(0, 7) != 0);
      sel = SEL_W'($urandom_range(0, 3));
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
